// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer.
// Holds the FSM state encoding, error codes, default sync byte and the
// inter-byte timeout calculation used to size the timeout counter.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPCODE  = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    localparam logic [1:0] ERR_FRAMING  = 2'b00;
    localparam logic [1:0] ERR_LENGTH   = 2'b01;
    localparam logic [1:0] ERR_CHECKSUM = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // One UART character is 10 bit times (start + 8 data + stop).
    function automatic int timeout_cycles(input int clk_freq, input int baud,
                                          input int chars);
        return chars * 10 * (clk_freq / baud);
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: loadable down-counter with clear, enable and expire.
// Latency: o_expire is combinational from the count; it asserts once TIMEOUT
// enabled cycles have elapsed since the last load. No backpressure.
// Ports: clk, rst (async, active high); i_clr forces the count to 0 and wins
// over i_load; i_load restarts the interval; i_en lets the counter run and
// qualifies o_expire.
module uart_cmd_timeout #(
    parameter int TIMEOUT = 125000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int              CW       = $clog2(TIMEOUT + 1);
    // Loaded with TIMEOUT-1 so that expiry lands exactly TIMEOUT cycles after
    // the load edge when no further load occurs.
    localparam logic [CW-1:0]   LOAD_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Turns the UART byte stream into checked commands (sync, opcode, len, payload[, xor]).
// Latency: cmd_valid one cycle after the final byte; err_pulse one cycle after the cause.
// Backpressure: command held until cmd_valid & cmd_ready; bytes arriving meanwhile are dropped and counted.
//
// Build option: define UART_CMD_CHECKSUM_EN to expect a trailing XOR byte
// (opcode ^ len ^ payload bytes) and enable the CHECK state / checksum error.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rx_byte, rx_done, rx_valid    byte stream from the UART receiver
//   cmd_valid, cmd_ready          command handshake
//   cmd_opcode, cmd_len, cmd_payload  command contents, stable while cmd_valid
//   err_pulse, err_code           one-cycle error strobe, code held until next error
//   drop_cnt                      saturating count of bytes dropped while holding
//   busy                          high whenever not hunting for sync
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int         CLK_FREQ      = 30_000_000,
    parameter int         BAUD          = 9600,
    parameter int         MAX_LEN       = 16,
    parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CHARS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     rx_byte,
    input  logic                           rx_done,
    input  logic                           rx_valid,
    output logic                           cmd_valid,
    input  logic                           cmd_ready,
    output logic [7:0]                     cmd_opcode,
    output logic [$clog2(MAX_LEN+1)-1:0]   cmd_len,
    output logic [8*MAX_LEN-1:0]           cmd_payload,
    output logic                           err_pulse,
    output logic [1:0]                     err_code,
    output logic [7:0]                     drop_cnt,
    output logic                           busy
);

    localparam int LW         = $clog2(MAX_LEN + 1);
    localparam int TMO_CYCLES = timeout_cycles(CLK_FREQ, BAUD, TIMEOUT_CHARS);

`ifdef UART_CMD_CHECKSUM_EN
    localparam state_t ST_FINAL = ST_CHECK;
`else
    localparam state_t ST_FINAL = ST_HOLD;
`endif

    state_t        r_state;
    state_t        w_state_nxt;

    logic [7:0]    r_opcode;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_idx;
    logic [7:0]    r_buf [MAX_LEN];
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]    r_xor;
`endif
    logic          r_err_pulse;
    logic [1:0]    r_err_code;
    logic [7:0]    r_drop_cnt;

    logic          w_idle_like;
    logic          w_cur_active;
    logic          w_next_active;
    logic          w_tmo_expire;
    logic          w_start;
    logic          w_abort;
    logic          w_clear;
    logic          w_op_we;
    logic          w_len_we;
    logic          w_pl_we;
    logic          w_drop;
    logic          w_err_fire;
    logic [1:0]    w_err_code;

    // The handshake cycle in HOLD behaves exactly like IDLE so a sync byte
    // arriving together with cmd_ready is not lost.
    assign w_idle_like   = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && cmd_ready);
    assign w_cur_active  = r_state inside {ST_OPCODE, ST_LEN, ST_PAYLOAD, ST_CHECK};
    assign w_next_active = w_state_nxt inside {ST_OPCODE, ST_LEN, ST_PAYLOAD, ST_CHECK};
    assign w_clear       = w_start || w_abort;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_abort     = 1'b0;
        w_op_we     = 1'b0;
        w_len_we    = 1'b0;
        w_pl_we     = 1'b0;
        w_drop      = 1'b0;
        w_err_fire  = 1'b0;
        w_err_code  = ERR_FRAMING;

        if (w_idle_like) begin
            w_state_nxt = ST_IDLE;
            if (rx_done) begin
                if (!rx_valid) begin
                    w_err_fire = 1'b1;
                    w_err_code = ERR_FRAMING;
                    w_abort    = 1'b1;
                end else if (rx_byte == SYNC_BYTE) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_OPCODE;
                end
            end
        end else if (r_state == ST_HOLD) begin
            // Command not yet taken: anything received is discarded.
            w_drop = rx_done;
        end else if (rx_done) begin
            // A received byte always beats a simultaneous timeout.
            if (!rx_valid) begin
                w_err_fire  = 1'b1;
                w_err_code  = ERR_FRAMING;
                w_abort     = 1'b1;
                w_state_nxt = ST_IDLE;
            end else begin
                case (r_state)
                    ST_OPCODE: begin
                        w_op_we     = 1'b1;
                        w_state_nxt = ST_LEN;
                    end
                    ST_LEN: begin
                        if (rx_byte > 8'(MAX_LEN)) begin
                            w_err_fire  = 1'b1;
                            w_err_code  = ERR_LENGTH;
                            w_abort     = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_len_we    = 1'b1;
                            w_state_nxt = (rx_byte == 8'd0) ? ST_FINAL : ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        w_pl_we = 1'b1;
                        if ((r_idx + LW'(1)) == r_len) begin
                            w_state_nxt = ST_FINAL;
                        end
                    end
`ifdef UART_CMD_CHECKSUM_EN
                    ST_CHECK: begin
                        if (rx_byte == r_xor) begin
                            w_state_nxt = ST_HOLD;
                        end else begin
                            w_err_fire  = 1'b1;
                            w_err_code  = ERR_CHECKSUM;
                            w_abort     = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
`endif
                    default: begin
                        w_abort     = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end else if (w_tmo_expire) begin
            w_err_fire  = 1'b1;
            w_err_code  = ERR_TIMEOUT;
            w_abort     = 1'b1;
            w_state_nxt = ST_IDLE;
        end
    end

    // ------------------------------------------------------- timeout counter
    // Held at zero whenever the next state is not a collecting state, and
    // restarted on every byte that keeps the frame alive.
    uart_cmd_timeout #(
        .TIMEOUT (TMO_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (!w_next_active),
        .i_load   (rx_done),
        .i_en     (w_cur_active),
        .o_expire (w_tmo_expire)
    );

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode    <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_buf[i] <= '0;
            end
`ifdef UART_CMD_CHECKSUM_EN
            r_xor       <= '0;
`endif
            r_err_pulse <= 1'b0;
            r_err_code  <= ERR_FRAMING;
            r_drop_cnt  <= '0;
        end else begin
            // Clearing on a new sync as well as on abort keeps unused payload
            // bytes at zero for every command.
            if (w_clear) begin
                r_opcode <= '0;
                r_len    <= '0;
                r_idx    <= '0;
                for (int i = 0; i < MAX_LEN; i++) begin
                    r_buf[i] <= '0;
                end
`ifdef UART_CMD_CHECKSUM_EN
                r_xor    <= '0;
`endif
            end else begin
                if (w_op_we) begin
                    r_opcode <= rx_byte;
                end
                if (w_len_we) begin
                    r_len <= rx_byte[LW-1:0];
                end
                if (w_pl_we) begin
                    r_idx <= r_idx + LW'(1);
                end
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (w_pl_we && (r_idx == LW'(i))) begin
                        r_buf[i] <= rx_byte;
                    end
                end
`ifdef UART_CMD_CHECKSUM_EN
                if (w_op_we || w_len_we || w_pl_we) begin
                    r_xor <= r_xor ^ rx_byte;
                end
`endif
            end

            r_err_pulse <= w_err_fire;
            if (w_err_fire) begin
                r_err_code <= w_err_code;
            end

            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        cmd_payload = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            cmd_payload[8*i +: 8] = r_buf[i];
        end
    end

    assign cmd_valid  = (r_state == ST_HOLD);
    assign busy       = (r_state != ST_IDLE);
    assign cmd_opcode = r_opcode;
    assign cmd_len    = r_len;
    assign err_pulse  = r_err_pulse;
    assign err_code   = r_err_code;
    assign drop_cnt   = r_drop_cnt;

endmodule
